// File: rtl/pwm_ds_demodulator.sv
// PWM delta-sigma receiver. It measures the high time in each PWM period of compare_max+1 cycles,
// boxcar-sums 2^DEC_LOG2 periods into one sample and offers that sample through a one-entry valid/ready buffer.
module pwm_ds_demodulator #(
    parameter int PWM_BITS    = 7,
    parameter int DEC_LOG2    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         pwm_in,
    input  logic [PWM_BITS-1:0]          compare_max,
    output logic [PWM_BITS:0]            width_out,
    output logic                         width_valid,
    output logic [PWM_BITS+DEC_LOG2:0]   sample,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic                         overrun,
    input  logic                         clear_overrun
);

    localparam int OUT_BITS = PWM_BITS + 1 + DEC_LOG2;

    logic                  pwm_s;
    logic [PWM_BITS-1:0]   phase_p0;
    logic [PWM_BITS:0]     hi_cnt_p0;
    logic [DEC_LOG2-1:0]   win_cnt_p0;
    logic [OUT_BITS-1:0]   acc_p0;

    logic                  win_end_p0;
    logic                  last_win_p0;
    logic                  load_p0;
    logic                  drop_p0;
    logic [PWM_BITS:0]     w_p0;
    logic [OUT_BITS-1:0]   result_p0;

    function automatic logic [OUT_BITS-1:0] widen(input logic [PWM_BITS:0] x);
        return {{DEC_LOG2{1'b0}}, x};
    endfunction

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign pwm_s = pwm_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= pwm_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign pwm_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Stage 0: window detection and period accumulation.
    // A ">=" compare lets a lowered compare_max terminate an overlong window on the next enabled cycle.
    assign win_end_p0  = en && (phase_p0 >= compare_max);
    assign w_p0        = hi_cnt_p0 + {{PWM_BITS{1'b0}}, pwm_s};
    assign last_win_p0 = (win_cnt_p0 == {DEC_LOG2{1'b1}});
    assign result_p0   = acc_p0 + widen(w_p0);
    assign load_p0     = win_end_p0 && last_win_p0;
    assign drop_p0     = load_p0 && sample_valid && !sample_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_p0   <= '0;
            hi_cnt_p0  <= '0;
            win_cnt_p0 <= '0;
            acc_p0     <= '0;
        end else if (en) begin
            if (win_end_p0) begin
                phase_p0  <= '0;
                hi_cnt_p0 <= '0;
                if (last_win_p0) begin
                    acc_p0     <= '0;
                    win_cnt_p0 <= '0;
                end else begin
                    acc_p0     <= result_p0;
                    win_cnt_p0 <= win_cnt_p0 + 1'b1;
                end
            end else begin
                phase_p0  <= phase_p0 + 1'b1;
                hi_cnt_p0 <= w_p0;
            end
        end
    end

    // Stage 1: width report and one-entry output buffer.
    // When the buffer is full and not being drained, the new result is dropped so that the held sample stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_out    <= '0;
            width_valid  <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            width_valid <= win_end_p0;
            if (win_end_p0) begin
                width_out <= w_p0;
            end

            if (load_p0) begin
                if (!sample_valid || sample_ready) begin
                    sample       <= result_p0;
                    sample_valid <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (drop_p0) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_ds_demodulator.sv
// Directed bench for pwm_ds_demodulator: it checks constant levels, a fixed duty cycle, backpressure, a pause, a mid-window reset
// and compare_max=0.
module tb_pwm_ds_demodulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic        pwm_in = 1'b0;
    logic [6:0]  cmax = 7'd127;
    logic [6:0]  cmax2 = 7'd0;
    logic        ready = 1'b1;
    logic        ready2 = 1'b1;
    logic        clear_ov = 1'b0;

    logic [7:0]  width_out;
    logic        width_valid;
    logic [11:0] sample;
    logic        sample_valid;
    logic        overrun;

    logic [7:0]  width2;
    logic        width_valid2;
    logic [8:0]  sample2;
    logic        sample_valid2;
    logic        overrun2;

    int   k = 0;
    int   mode = 0;
    logic level = 1'b0;
    int   total = 0;
    int   bad = 0;

    pwm_ds_demodulator dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in), .compare_max(cmax),
        .width_out(width_out), .width_valid(width_valid), .sample(sample),
        .sample_valid(sample_valid), .sample_ready(ready), .overrun(overrun),
        .clear_overrun(clear_ov)
    );

    pwm_ds_demodulator #(.DEC_LOG2(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in), .compare_max(cmax2),
        .width_out(width2), .width_valid(width_valid2), .sample(sample2),
        .sample_valid(sample_valid2), .sample_ready(ready2), .overrun(overrun2),
        .clear_overrun(clear_ov)
    );

    always #5 clk = ~clk;

    function automatic logic pat(input int kk);
        if (mode == 0) return level;
        if (mode == 1) return (((kk + 2) % 128) < 37);
        return kk[0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        pwm_in = pat(k);
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic wait_sig(input int which, input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!((which == 0) ? width_valid : sample_valid) && n < budget);
        chk(tag, (which == 0) ? width_valid : sample_valid, 1'b1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        en = 1'b1;
        clear_ov = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        k = 0;
        pwm_in = pat(0);
    endtask

    initial begin
        int wv;
        // Reset values.
        tick();
        tick();
        chk("rst_outs", {width_out, width_valid, sample, sample_valid, overrun}, 0);
        chk("rst_outs2", {width2, width_valid2, sample2, sample_valid2, overrun2}, 0);

        // Constant high. The first window loses two cycles in the reset-cleared synchroniser.
        mode = 0; level = 1'b1; ready = 1'b1;
        reset_dut();
        wait_sig(0, 300, "wait_w1");
        chk("hi_w1_time", k, 128);
        chk("hi_w1", width_out, 126);
        wait_sig(0, 300, "wait_w2");
        chk("hi_w2_time", k, 256);
        chk("hi_w2", width_out, 128);
        wait_sig(1, 2100, "wait_s1");
        chk("hi_s1_time", k, 2048);
        chk("hi_s1", sample, 2046);
        tick();
        chk("hi_s1_pulse", sample_valid, 0);
        wait_sig(1, 2100, "wait_s2");
        chk("hi_s2_time", k, 4096);
        chk("hi_s2", sample, 2048);

        // Pause 50 cycles mid-window; everything shifts by 50.
        run_to(4160);
        en = 1'b0;
        wv = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            wv += width_valid;
        end
        chk("pause_wv", wv, 0);
        en = 1'b1;
        wait_sig(0, 300, "wait_pw");
        chk("pause_w_time", k, 4274);
        chk("pause_w", width_out, 128);
        wait_sig(1, 2100, "wait_ps");
        chk("pause_s_time", k, 6194);
        chk("pause_s", sample, 2048);

        // Constant low. Two ones are still in the synchroniser.
        level = 1'b0;
        pwm_in = pat(k);
        wait_sig(1, 2100, "wait_lo1");
        chk("lo_s1_time", k, 8242);
        chk("lo_s1", sample, 2);
        wait_sig(1, 2100, "wait_lo2");
        chk("lo_s2", sample, 0);

        // Fixed duty 37/128.
        mode = 1; ready = 1'b1;
        reset_dut();
        wait_sig(0, 300, "wait_d1");
        chk("duty_w1_time", k, 128);
        chk("duty_w1", width_out, 35);
        wait_sig(0, 300, "wait_d2");
        chk("duty_w2", width_out, 37);
        wait_sig(1, 2100, "wait_ds1");
        chk("duty_s1_time", k, 2048);
        chk("duty_s1", sample, 590);

        // Backpressure: hold sample, drop the next one, set wins over clear.
        ready = 1'b0;
        run_to(4095);
        chk("bp_pre_ovr", overrun, 0);
        chk("bp_pre_vld", sample_valid, 1);
        tick();
        chk("bp_hold", sample, 590);
        chk("bp_ovr", overrun, 1);
        run_to(6143);
        clear_ov = 1'b1;
        tick();
        clear_ov = 1'b0;
        chk("bp_setwins", overrun, 1);
        chk("bp_hold2", sample, 590);
        tick();
        clear_ov = 1'b1;
        tick();
        clear_ov = 1'b0;
        chk("bp_clear", overrun, 0);

        // Asynchronous reset at phase 60 of window 9.
        run_to(7356);
        rst_n = 1'b0;
        #1;
        chk("mid_rst", {width_out, width_valid, sample, sample_valid, overrun}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        k = 0;
        pwm_in = pat(0);
        ready = 1'b1;
        wait_sig(1, 2100, "wait_mr");
        chk("mr_s_time", k, 2048);
        chk("mr_s", sample, 590);

        // Accept and load in the same cycle.
        ready = 1'b0;
        run_to(4095);
        chk("sim_vld_pre", sample_valid, 1);
        ready = 1'b1;
        tick();
        chk("sim_s", sample, 592);
        chk("sim_vld", sample_valid, 1);
        chk("sim_ovr", overrun, 0);
        tick();
        chk("sim_drain", sample_valid, 0);

        // compare_max=0 with DEC_LOG2=1 and a toggling input.
        mode = 2;
        reset_dut();
        run_to(4);
        for (int i = 0; i < 8; i++) begin
            chk("cm0_vld", sample_valid2, (k % 2) == 0);
            chk("cm0_s", sample2, 1);
            chk("cm0_w", width2, (k - 3) % 2);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog k=%0d", k);
        $fatal(1, "timeout");
    end

endmodule
